// File: rtl/bram_stream_reader_if.sv
// Stream interface between bram_stream_reader and the CNN compute datapath.
// One beat carries the four BRAM lanes packed as {lane3, lane2, lane1, lane0}.
interface bram_stream_reader_if #(
  parameter int unsigned BRAM_WIDTH = 32
);
  logic [4*BRAM_WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    m_valid;
  logic                    m_ready;

  modport master (
    output m_data,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a 4-lane BRAM bank word by word and streams each word-set
// over a valid/ready handshake. Read latency is hidden by a small skid FIFO whose
// free space is tracked as credits, so the stream sustains one beat per cycle and
// never loses data under backpressure.
//
// Build option: define BRAM_RD_OREG_EN when the BRAM output register is enabled
// (read latency 2, FIFO depth 3). Undefined: read latency 1, FIFO depth 2.
module bram_stream_reader #(
  parameter int unsigned BRAM_ADDR_BIT = 32,
  parameter int unsigned BRAM_WIDTH    = 32,
  parameter int unsigned BRAM_BYTE     = BRAM_ADDR_BIT / 8,
  parameter int unsigned ADDR_STEP     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // Control
  input  logic                     rd_start,
  input  logic [BRAM_ADDR_BIT-1:0] rd_base,
  input  logic [31:0]              rd_quantity,
  output logic                     rd_busy,
  output logic                     rd_done,
  // BRAM read port (shared by all four lanes)
  output logic                     BRAM_RD_clk,
  output logic                     BRAM_RD_en,
  output logic                     BRAM_RD_rst,
  output logic [BRAM_BYTE-1:0]     BRAM_RD_wen,
  output logic [BRAM_ADDR_BIT-1:0] BRAM_RD_addr,
  input  logic [BRAM_WIDTH-1:0]    BRAM0_RD_dout,
  input  logic [BRAM_WIDTH-1:0]    BRAM1_RD_dout,
  input  logic [BRAM_WIDTH-1:0]    BRAM2_RD_dout,
  input  logic [BRAM_WIDTH-1:0]    BRAM3_RD_dout,
  // Output stream
  bram_stream_reader_if.master     m_if
);

`ifdef BRAM_RD_OREG_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif
  localparam int unsigned Depth = Lat + 1;
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned DataW = 4 * BRAM_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e                   state_q;
  logic [31:0]              quantity_q;
  logic [31:0]              issued_q;
  logic [31:0]              accepted_q;
  logic [BRAM_ADDR_BIT-1:0] addr_q;
  logic                     done_q;

  // One bit per outstanding read; bit Lat-1 marks the cycle its data is on dout.
  logic [Lat-1:0]           pipe_q;

  logic [DataW-1:0]         mem_q [Depth];
  logic [PtrW-1:0]          wr_ptr_q;
  logic [PtrW-1:0]          rd_ptr_q;
  logic [CntW-1:0]          count_q;

  logic                     fifo_valid;
  logic                     push;
  logic                     pop;
  logic                     issue;
  logic [31:0]              inflight;
  logic [31:0]              occupancy;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credit check: a read may issue only if its data is guaranteed a FIFO slot,
  // counting a slot freed by a beat leaving in this same cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(Lat); i++) begin
      inflight = inflight + {31'd0, pipe_q[i]};
    end
    fifo_valid = (count_q != '0);
    pop        = fifo_valid & m_if.m_ready;
    push       = pipe_q[Lat-1];
    occupancy  = {{(32 - CntW){1'b0}}, count_q} + inflight;
    issue      = (state_q == StRun) && (issued_q != quantity_q) &&
                 (occupancy < (Depth + {31'd0, pop}));
  end

  // Control FSM: start latching, issue/accept counting, address stepping, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      quantity_q <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        addr_q   <= addr_q + BRAM_ADDR_BIT'(ADDR_STEP);
        issued_q <= issued_q + 32'd1;
      end
      if (pop) begin
        accepted_q <= accepted_q + 32'd1;
      end
      case (state_q)
        StIdle: begin
          if (rd_start) begin
            quantity_q <= rd_quantity;
            addr_q     <= rd_base;
            issued_q   <= '0;
            accepted_q <= '0;
            // An empty transfer completes without ever becoming busy.
            if (rd_quantity == 32'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (issue && (issued_q + 32'd1 == quantity_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && (accepted_q + 32'd1 == quantity_q)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read-latency tracker: shifts each issue along until its data appears on dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < int'(Lat); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Skid FIFO: captures returning lane data, presents the head as the stream beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {BRAM3_RD_dout, BRAM2_RD_dout, BRAM1_RD_dout, BRAM0_RD_dout};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Output drive; the FIFO is in order, so the head word index equals accepted_q.
  always_comb begin
    m_if.m_valid = fifo_valid;
    m_if.m_data  = fifo_valid ? mem_q[rd_ptr_q] : '0;
    m_if.m_last  = fifo_valid && (accepted_q == quantity_q - 32'd1);
    BRAM_RD_clk  = clk;
    BRAM_RD_en   = issue;
    BRAM_RD_rst  = 1'b0;
    BRAM_RD_wen  = '0;
    BRAM_RD_addr = addr_q;
    rd_busy      = (state_q != StIdle);
    rd_done      = done_q;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: table of transfers plus random transfers, each checked
// against an ordered model of the expected beats (lane k of word i derives from the
// byte address base + 4*i), and hand-written reset sequences.
module tb_bram_stream_reader;

`ifdef BRAM_RD_OREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int Depth = Lat + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_start = 1'b0;
  logic [31:0]  rd_base = '0;
  logic [31:0]  rd_quantity = '0;
  logic         rd_busy, rd_done;
  logic         bram_clk, bram_en, bram_rst;
  logic [3:0]   bram_wen;
  logic [31:0]  bram_addr;
  logic [31:0]  d0, d1, d2, d3;
  logic [31:0]  ra1 = '0;
  logic [31:0]  ra2 = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_stream_reader_if #(.BRAM_WIDTH(32)) s_if ();

  bram_stream_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_start      (rd_start),
    .rd_base       (rd_base),
    .rd_quantity   (rd_quantity),
    .rd_busy       (rd_busy),
    .rd_done       (rd_done),
    .BRAM_RD_clk   (bram_clk),
    .BRAM_RD_en    (bram_en),
    .BRAM_RD_rst   (bram_rst),
    .BRAM_RD_wen   (bram_wen),
    .BRAM_RD_addr  (bram_addr),
    .BRAM0_RD_dout (d0),
    .BRAM1_RD_dout (d1),
    .BRAM2_RD_dout (d2),
    .BRAM3_RD_dout (d3),
    .m_if          (s_if)
  );

  function automatic logic [31:0] lane_word(input logic [31:0] a, input int k);
    return (a >> 2) + (32'(k) << 28);
  endfunction

  function automatic logic [127:0] beat_word(input logic [31:0] a);
    return {lane_word(a, 3), lane_word(a, 2), lane_word(a, 1), lane_word(a, 0)};
  endfunction

  // BRAM behavioural model: synchronous read, optional extra output register.
  always @(posedge clk) begin
    if (bram_en) ra1 <= bram_addr;
    ra2 <= ra1;
  end
`ifdef BRAM_RD_OREG_EN
  assign d0 = lane_word(ra2, 0);
  assign d1 = lane_word(ra2, 1);
  assign d2 = lane_word(ra2, 2);
  assign d3 = lane_word(ra2, 3);
`else
  assign d0 = lane_word(ra1, 0);
  assign d1 = lane_word(ra1, 1);
  assign d2 = lane_word(ra1, 2);
  assign d3 = lane_word(ra1, 3);
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    {127'd0, bram_en}, 128'd0);
    chk({tag, "_addr"},  {96'd0, bram_addr}, 128'd0);
    chk({tag, "_valid"}, {127'd0, s_if.m_valid}, 128'd0);
    chk({tag, "_last"},  {127'd0, s_if.m_last}, 128'd0);
    chk({tag, "_data"},  s_if.m_data, 128'd0);
    chk({tag, "_busy"},  {127'd0, rd_busy}, 128'd0);
    chk({tag, "_done"},  {127'd0, rd_done}, 128'd0);
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 1;
      2:       return 1'($urandom_range(0, 1));
      default: return !(cyc >= 6 && cyc < 26);
    endcase
  endfunction

  // Runs one transfer (start accepted at the edge ending cycle 0) and checks every beat.
  task automatic run_xfer(input logic [31:0] base, input int qty, input int mode,
                          input int restart_cyc, output int beats, output int dones,
                          output int first_v, output int last_v, output int done_cyc);
    int cyc;
    int issued;
    logic prev_stall;
    logic [127:0] prev_data;
    beats = 0; dones = 0; first_v = -1; last_v = -1; done_cyc = -1;
    issued = 0; prev_stall = 1'b0; prev_data = '0;
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = base; rd_quantity = 32'(qty);
    @(posedge clk); #1;
    rd_start = 1'b0; rd_base = $urandom; rd_quantity = $urandom;
    cyc = 1;
    while (cyc < 400) begin
      s_if.m_ready = ready_for(mode, cyc);
      rd_start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        rd_base = 32'hDEAD_0000; rd_quantity = 32'd3;
      end
      @(negedge clk);
      if (bram_en) begin
        chk("issue_addr", {96'd0, bram_addr}, {96'd0, base + 32'(4 * issued)});
        issued++;
      end
      if (s_if.m_valid) begin
        if (first_v < 0) first_v = cyc;
        if (beats >= qty) begin
          chk("extra_beat", 128'd1, 128'd0);
        end else begin
          chk("beat_data", s_if.m_data, beat_word(base + 32'(4 * beats)));
          chk("beat_last", {127'd0, s_if.m_last}, {127'd0, beats == qty - 1});
        end
        if (prev_stall) chk("stall_hold", s_if.m_data, prev_data);
        prev_stall = !s_if.m_ready;
        prev_data  = s_if.m_data;
        if (s_if.m_ready) begin
          beats++;
          last_v = cyc;
        end
      end else begin
        if (prev_stall) chk("stall_valid_drop", 128'd0, 128'd1);
        prev_stall = 1'b0;
      end
      chk("outstanding_le_D", {127'd0, (issued - beats) <= Depth}, 128'd1);
      if (qty == 0) chk("busy_zero_qty", {127'd0, rd_busy}, 128'd0);
      if (cyc == 1 && qty > 0) chk("busy_after_start", {127'd0, rd_busy}, 128'd1);
      if (rd_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(posedge clk); #1;
      cyc++;
    end
    rd_start = 1'b0;
    if (done_cyc < 0) chk("timeout_no_done", 128'd0, 128'd1);
    chk("issued_count", 128'(issued), 128'(qty));
  endtask

  typedef struct {
    logic [31:0] base;
    int          qty;
    int          mode;
    int          restart_cyc;
    int          exp_beats;
    int          exp_dones;
    int          exp_first;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int beats, dones, first_v, last_v, done_cyc, got;
    s_if.m_ready = 1'b0;

    vecs[0] = '{32'h0000_0000,  4, 0, -1,  4, 1, Lat + 2};
    vecs[1] = '{32'h0000_0100,  8, 1, -1,  8, 1, -1};
    vecs[2] = '{32'h0000_0040, 12, 3, -1, 12, 1, -1};
    vecs[3] = '{32'h0000_0000,  0, 0, -1,  0, 1, -1};
    vecs[4] = '{32'h0000_2000, 16, 0,  5, 16, 1, Lat + 2};
    vecs[5] = '{32'hFFFF_FFF8,  4, 0, -1,  4, 1, Lat + 2};
    vecs[6] = '{32'h0000_0010,  1, 0, -1,  1, 1, Lat + 2};
    vecs[7] = '{32'h0000_0080,  6, 2, -1,  6, 1, -1};

    #2;
    chk_reset_outputs("reset");
    chk("bram_rst_tied", {127'd0, bram_rst}, 128'd0);
    chk("bram_wen_tied", {124'd0, bram_wen}, 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].base, vecs[i].qty, vecs[i].mode, vecs[i].restart_cyc,
               beats, dones, first_v, last_v, done_cyc);
      chk("beat_count", 128'(beats), 128'(vecs[i].exp_beats));
      chk("done_count", 128'(dones), 128'(vecs[i].exp_dones));
      if (vecs[i].exp_first >= 0) begin
        chk("first_valid_cyc", 128'(first_v), 128'(vecs[i].exp_first));
        chk("back_to_back", 128'(last_v - first_v), 128'(vecs[i].qty - 1));
      end
      chk("done_cyc", 128'(done_cyc), 128'(vecs[i].qty == 0 ? 1 : last_v + 1));
      if (vecs[i].qty == 0) chk("zero_qty_no_valid", 128'(first_v), -128'sd1);
    end

    for (int r = 0; r < 10; r++) begin
      logic [31:0] b;
      int q, m;
      b = $urandom;
      q = $urandom_range(1, 12);
      m = $urandom_range(0, 3);
      run_xfer(b, q, m, -1, beats, dones, first_v, last_v, done_cyc);
      chk("rand_beat_count", 128'(beats), 128'(q));
      chk("rand_done_count", 128'(dones), 128'd1);
      chk("rand_done_cyc", 128'(done_cyc), 128'(last_v + 1));
    end

    // Reset in the middle of a 10-word stream after 5 beats.
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = 32'h300; rd_quantity = 32'd10; s_if.m_ready = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      if (s_if.m_valid && s_if.m_ready) got++;
      @(posedge clk); #1;
    end
    chk("mid_reset_reach_5", 128'(got), 128'd5);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_valid", {127'd0, s_if.m_valid}, 128'd0);
      chk("post_reset_done", {127'd0, rd_done}, 128'd0);
    end
    run_xfer(32'h500, 3, 0, -1, beats, dones, first_v, last_v, done_cyc);
    chk("fresh_beat_count", 128'(beats), 128'd3);
    chk("fresh_done_count", 128'(dones), 128'd1);
    chk("fresh_first_valid", 128'(first_v), 128'(Lat + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
